switch_input_port: RTL and testbench

- Parametrised Avalon-MM slave that samples WIDTH board switches or buttons.
- Each input gets a synchroniser and a per-bit debouncer.
- Exposes the debounced level, sticky edge-capture bits, an interrupt mask and an edge-mode select.
- Drives a level interrupt to the Nios II / HPS interrupt controller and sits on the lightweight peripheral bus beside the other custom IP.

---
 rtl/switch_input_port_pkg.sv | 25 ++
 rtl/switch_input_port_debounce_bit.sv | 45 ++++
 rtl/switch_input_port.sv | 85 ++++++++
 tb/tb_switch_input_port.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/switch_input_port_pkg.sv
// Shared register-map addresses and edge-mode encodings for switch_input_port.
package switch_input_port_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_EDGE = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CFG  = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_RSVD = 2'b11
  } edge_mode_t;

  // The reserved encoding behaves like EDGE_BOTH.
  function automatic logic edge_hit(edge_mode_t mode, logic changed, logic level);
    case (mode)
      EDGE_RISE: edge_hit = changed & level;
      EDGE_FALL: edge_hit = changed & ~level;
      default:   edge_hit = changed;
    endcase
  endfunction

endpackage

// File: rtl/switch_input_port_debounce_bit.sv
// One channel: SYNC_STAGES-flop synchroniser, then a counter that accepts a new level after
// DEBOUNCE_CYCLES stable cycles; changed pulses for one cycle alongside the new stable value.
module switch_input_port_debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic changed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      cnt     <= '0;
      stable  <= 1'b0;
      changed <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      changed <= 1'b0;
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Terminal count: accept the level; counter never reaches a wrapping value.
        stable  <= sync;
        changed <= 1'b1;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/switch_input_port.sv
// Avalon-MM switch/button port: debounced level, sticky edge capture, mask, masked level irq.
// Reads return data one cycle after the strobe with no waitrequest; the slave never stalls.
module switch_input_port #(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] switch
);

  import switch_input_port_pkg::*;

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] changed;
  logic [WIDTH-1:0] events;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] w1c;
  edge_mode_t       edge_mode;
  logic             wr_en;
  logic             rd_en;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    switch_input_port_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (switch[i]),
      .stable (stable[i]),
      .changed(changed[i])
    );
    assign events[i] = edge_hit(edge_mode, changed[i], stable[i]);
  end

  assign wr_en        = write & chipselect;
  assign rd_en        = read & chipselect;
  assign w1c          = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = stable;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      default:   rd_mux[1:0]       = edge_mode;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata     <= '0;
      irq          <= 1'b0;
      edge_capture <= '0;
      irq_mask     <= '0;
      edge_mode    <= EDGE_RISE;
    end else begin
      readdata     <= rd_en ? rd_mux : '0;
      // A fresh event outranks a same-cycle clear so no edge is lost.
      edge_capture <= (edge_capture & ~w1c) | events;
      irq          <= |(edge_capture & irq_mask);
      if (wr_en) begin
        case (address)
          ADDR_MASK: irq_mask  <= writedata[WIDTH-1:0];
          ADDR_CFG:  edge_mode <= edge_mode_t'(writedata[1:0]);
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_switch_input_port.sv
// Bench for switch_input_port with short debounce: register tables plus timed corner sequences.
module tb_switch_input_port;

  localparam int W = 10;
  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_EDGE = 2'd1;
  localparam logic [1:0] A_MASK = 2'd2;
  localparam logic [1:0] A_CFG  = 2'd3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic          irq;
  logic [W-1:0]  switch = '0;

  always #5 clk = ~clk;

  switch_input_port #(
    .WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata),
    .irq(irq), .switch(switch)
  );

  typedef struct { logic [31:0] exp; string name; } sb_t;
  typedef struct { logic wr; logic [1:0] addr; logic [31:0] data; logic [31:0] exp; string name; } vec_t;

  sb_t  sb[$];
  vec_t rst_vecs[$];
  vec_t reg_vecs[$];
  int   errors = 0;
  int   checks = 0;
  logic rd_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge reset_n)
    if (!reset_n) rd_seen <= 1'b0;
    else          rd_seen <= read & chipselect;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: readdata %h with no expected entry", readdata);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check(e.name, readdata, e.exp);
      end
    end
  end

  task automatic push_exp(input logic [31:0] exp, input string name);
    sb_t e;
    e.exp = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    @(negedge clk);
    write = 1'b0; chipselect = 1'b0; writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    address = a; chipselect = 1'b1; read = 1'b1;
    push_exp(exp, name);
    @(negedge clk);
    read = 1'b0; chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic add_vec(ref vec_t q[$], input logic wr, input logic [1:0] a,
                         input logic [31:0] d, input logic [31:0] exp, input string name);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.exp = exp; v.name = name;
    q.push_back(v);
  endtask

  task automatic run_vecs(input vec_t q[$]);
    foreach (q[i]) begin
      if (q[i].wr) bus_write(q[i].addr, q[i].data);
      else         bus_read(q[i].addr, q[i].exp, q[i].name);
    end
  endtask

  initial begin
    for (int a = 0; a < 4; a++)
      add_vec(rst_vecs, 1'b0, 2'(a), 32'h0, 32'h0, $sformatf("reset_read_a%0d", a));
    add_vec(reg_vecs, 1'b1, A_MASK, 32'hFFFF_FFFF, 32'h0,   "");
    add_vec(reg_vecs, 1'b0, A_MASK, 32'h0,         32'h3FF, "mask_upper_zero");
    add_vec(reg_vecs, 1'b1, A_CFG,  32'h0000_00FF, 32'h0,   "");
    add_vec(reg_vecs, 1'b0, A_CFG,  32'h0,         32'h3,   "cfg_upper_zero");
    add_vec(reg_vecs, 1'b1, A_DATA, 32'h0000_03FF, 32'h0,   "");
    add_vec(reg_vecs, 1'b0, A_DATA, 32'h0,         32'h0,   "data_read_only");
    add_vec(reg_vecs, 1'b1, A_MASK, 32'h0,         32'h0,   "");
    add_vec(reg_vecs, 1'b0, A_MASK, 32'h0,         32'h0,   "mask_cleared");
    add_vec(reg_vecs, 1'b1, A_CFG,  32'h0,         32'h0,   "");
    add_vec(reg_vecs, 1'b0, A_CFG,  32'h0,         32'h0,   "cfg_rise");

    idle(3);
    reset_n = 1'b1;
    check("reset_irq", {31'h0, irq}, 32'h0);
    run_vecs(rst_vecs);

    // Latency: DATA holds until the level is accepted SYNC_STAGES+DEBOUNCE_CYCLES edges later.
    switch = 10'h155;
    for (int k = 0; k < 7; k++)
      bus_read(A_DATA, (k < 6) ? 32'h0 : 32'h155, $sformatf("data_latency_%0d", k));
    idle(13);
    bus_read(A_DATA, 32'h155, "data_hold");
    bus_read(A_EDGE, 32'h155, "edge_rise_all");
    check("irq_masked", {31'h0, irq}, 32'h0);
    bus_write(A_EDGE, 32'h3FF);
    bus_read(A_EDGE, 32'h0, "w1c_all");

    switch = '0;
    idle(12);
    bus_read(A_DATA, 32'h0, "data_fall");
    bus_read(A_EDGE, 32'h0, "rise_ignores_fall");
    switch[0] = 1'b1;
    idle(3);
    switch[0] = 1'b0;
    idle(10);
    bus_read(A_DATA, 32'h0, "glitch_data");
    bus_read(A_EDGE, 32'h0, "glitch_edge");

    run_vecs(reg_vecs);

    bus_write(A_MASK, 32'h1);
    switch[0] = 1'b1;
    idle(7);
    check("irq_before_lag", {31'h0, irq}, 32'h0);
    idle(1);
    check("irq_set", {31'h0, irq}, 32'h1);
    bus_read(A_EDGE, 32'h1, "edge_bit0");
    bus_write(A_EDGE, 32'h1);
    bus_read(A_EDGE, 32'h0, "w1c_bit0");
    check("irq_cleared", {31'h0, irq}, 32'h0);

    bus_write(A_CFG, 32'h1);
    switch[3] = 1'b1;
    idle(10);
    bus_read(A_EDGE, 32'h0, "fall_mode_rise");
    switch[3] = 1'b0;
    idle(10);
    bus_read(A_EDGE, 32'h8, "fall_mode_fall");
    check("irq_unmasked_bit", {31'h0, irq}, 32'h0);
    bus_write(A_CFG, 32'h2);
    bus_read(A_EDGE, 32'h8, "mode_change_keeps");
    bus_read(A_CFG, 32'h2, "cfg_both");
    bus_write(A_EDGE, 32'h8);
    bus_read(A_EDGE, 32'h0, "w1c_bit3");

    // Same-cycle read and write of MASK returns the old value.
    address = A_MASK; chipselect = 1'b1; read = 1'b1; write = 1'b1; writedata = 32'h2AA;
    push_exp(32'h1, "rw_pre_write");
    @(negedge clk);
    read = 1'b0; write = 1'b0; chipselect = 1'b0; writedata = '0;
    bus_read(A_MASK, 32'h2AA, "rw_post_write");
    bus_write(A_MASK, 32'h1);

    // Clear on bit2 lands on the same edge that captures bit2's rising event.
    switch[2] = 1'b1;
    idle(6);
    bus_write(A_EDGE, 32'h4);
    bus_read(A_EDGE, 32'h4, "w1c_vs_set");
    bus_read(A_DATA, 32'h5, "data_pre_reset");

    bus_write(A_MASK, 32'h3FF);
    idle(1);
    check("irq_pre_reset", {31'h0, irq}, 32'h1);
    switch = 10'h0F5;
    idle(2);
    address = A_EDGE; chipselect = 1'b1; read = 1'b1;
    @(posedge clk);
    #2;
    read = 1'b0; chipselect = 1'b0;
    check("readdata_pre_reset", readdata, 32'h4);
    reset_n = 1'b0;
    #1;
    check("async_reset_readdata", readdata, 32'h0);
    check("async_reset_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    idle(1);
    reset_n = 1'b1;
    bus_read(A_MASK, 32'h0, "mask_after_reset");
    bus_read(A_CFG,  32'h0, "cfg_after_reset");
    bus_read(A_EDGE, 32'h0, "edge_after_reset");
    bus_read(A_DATA, 32'h0, "data_requalify_pending");
    idle(10);
    bus_read(A_DATA, 32'h0F5, "data_requalify");
    bus_read(A_EDGE, 32'h0F5, "edge_requalify");
    check("irq_after_reset", {31'h0, irq}, 32'h0);

    idle(2);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
